// File: rtl/zoe_seg_reader.sv
// zoe_seg_reader: reads back a seven-segment bus, waits for a stable glyph,
// decodes it to a hex code plus blank/invalid flags, and presents it on a
// valid/ready port with sticky overrun and an accepted-glyph counter.
module zoe_seg_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_code,
  output logic       out_blank,
  output logic       out_invalid,
  output logic       overrun,
  output logic [7:0] glyph_count
);

  // Counter threshold: cnt saturates here, one below the hold length.
  localparam logic [7:0] STABLE_M1 = 8'(STABLE_CYCLES - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t     state;
  logic [7:1] sync_meta;
  logic [7:1] sync_out;
  logic [7:0] seg_s;
  logic [7:0] cand;
  logic [7:0] cnt;
  logic [7:0] last;
  logic       accept;
  logic [3:0] dec_code;
  logic       dec_blank;
  logic       dec_invalid;

  // Bit 0 of the bus carries no segment, so it is dropped before the sync.
  assign seg_s = {sync_out, 1'b0};

  // Two-flop synchronizer for the asynchronous segment lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync_out  <= '0;
    end else begin
      sync_meta <= seg_in[7:1];
      sync_out  <= sync_meta;
    end
  end

  // A pattern is accepted once it has matched cand for STABLE_CYCLES edges
  // and differs from the previously accepted pattern.
  assign accept = (seg_s == cand) && (cnt >= STABLE_M1) && (cand != last);

  // Stability filter: restart on any change, saturate the hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= '0;
      cnt  <= '0;
      last <= '0;
    end else if (seg_s != cand) begin
      cand <= seg_s;
      cnt  <= '0;
    end else if (cnt < STABLE_M1) begin
      cnt <= cnt + 8'd1;
    end else if (cand != last) begin
      last <= cand;
    end
  end

  // Glyph decode of the candidate pattern (bit 0 is always zero here).
  always_comb begin
    dec_code    = 4'h0;
    dec_blank   = 1'b0;
    dec_invalid = 1'b0;
    case (cand)
      8'h7E: dec_code = 4'h0;
      8'h0C: dec_code = 4'h1;
      8'hB6: dec_code = 4'h2;
      8'h9E: dec_code = 4'h3;
      8'hCC: dec_code = 4'h4;
      8'hDA: dec_code = 4'h5;
      8'hFA: dec_code = 4'h6;
      8'h0E: dec_code = 4'h7;
      8'hFE: dec_code = 4'h8;
      8'hDE: dec_code = 4'h9;
      8'hEE: dec_code = 4'hA;
      8'hF8: dec_code = 4'hB;
      8'h72: dec_code = 4'hC;
      8'hBC: dec_code = 4'hD;
      8'hF2: dec_code = 4'hE;
      8'hE2: dec_code = 4'hF;
      8'h00: dec_blank = 1'b1;
      default: dec_invalid = 1'b1;
    endcase
  end

  // Output holding register: load on accept, drain on handshake, flag overwrite.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      out_valid   <= 1'b0;
      out_code    <= 4'h0;
      out_blank   <= 1'b0;
      out_invalid <= 1'b0;
      overrun     <= 1'b0;
      glyph_count <= 8'h00;
    end else if (accept) begin
      state       <= FULL;
      out_valid   <= 1'b1;
      out_code    <= dec_code;
      out_blank   <= dec_blank;
      out_invalid <= dec_invalid;
      glyph_count <= glyph_count + 8'd1;
      if (state == FULL && !out_ready) begin
        overrun <= 1'b1;
      end
    end else if (state == FULL && out_ready) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_zoe_seg_reader.sv
// Scoreboard bench for zoe_seg_reader: the stimulus tasks predict each accept
// and push the expected glyph; a monitor pops and compares on each handshake.
module tb_zoe_seg_reader;

  localparam int STABLE = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] seg_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_code;
  logic       out_blank;
  logic       out_invalid;
  logic       overrun;
  logic [7:0] glyph_count;

  int checks;
  int failures;

  // Expected glyph packed as {blank, invalid, code}.
  logic [5:0] sb_q[$];
  logic [7:0] model_last;
  logic [7:0] model_count;
  bit         replace_mode;

  // Segment pattern for each hex digit, indexed by code.
  logic [7:0] glyph_tab [16];

  zoe_seg_reader #(.STABLE_CYCLES(STABLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .out_blank  (out_blank),
    .out_invalid(out_invalid),
    .overrun    (overrun),
    .glyph_count(glyph_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] expect_of(input logic [7:0] pat);
    logic [5:0] r;
    r = {2'b01, 4'h0};
    if (pat == 8'h00) r = {2'b10, 4'h0};
    for (int i = 0; i < 16; i++)
      if (glyph_tab[i] == pat) r = {2'b00, 4'(i)};
    return r;
  endfunction

  // Drive a pattern and predict whether it will be accepted after `cycles`.
  task automatic drive_glyph(input logic [7:0] pat, input int cycles);
    logic [7:0] m;
    m = pat & 8'hFE;
    seg_in = pat;
    if (m != model_last && cycles >= STABLE + 1) begin
      if (replace_mode && sb_q.size() > 0) void'(sb_q.pop_back());
      sb_q.push_back(expect_of(m));
      model_last  = m;
      model_count = model_count + 8'd1;
    end
  endtask

  task automatic hold_glyph(input logic [7:0] pat, input int cycles);
    drive_glyph(pat, cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    seg_in    = 8'h00;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    sb_q.delete();
    model_last  = 8'h00;
    model_count = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake must match the oldest predicted glyph.
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_val("unexpected_glyph", {out_blank, out_invalid, out_code}, 6'h3F);
        end else begin
          e = sb_q.pop_front();
          check_val("glyph", {out_blank, out_invalid, out_code}, e);
          $display("glyph code=%0h blank=%0b invalid=%0b count=%0d",
                   out_code, out_blank, out_invalid, glyph_count);
        end
      end
    end
  end

  initial begin
    logic [7:0] sweep [18];
    glyph_tab = '{8'h7E, 8'h0C, 8'hB6, 8'h9E, 8'hCC, 8'hDA, 8'hFA, 8'h0E,
                  8'hFE, 8'hDE, 8'hEE, 8'hF8, 8'h72, 8'hBC, 8'hF2, 8'hE2};
    checks = 0;
    failures = 0;
    replace_mode = 1'b0;
    seg_in = 8'h00;
    out_ready = 1'b0;
    rst_n = 1'b0;
    model_last = 8'h00;
    model_count = 8'h00;
    #2;
    check_val("rst_valid", out_valid, 0);
    check_val("rst_code", out_code, 0);
    check_val("rst_flags", {out_blank, out_invalid, overrun}, 0);
    check_val("rst_count", glyph_count, 0);
    do_reset();

    // Basic decode and first-accept latency.
    drive_glyph(8'h7E, 10);
    repeat (STABLE + 2) @(posedge clk);
    #1 check_val("lat_not_yet", out_valid, 0);
    @(posedge clk);
    #1 check_val("lat_valid", out_valid, 1);
    check_val("basic_code", out_code, 0);
    check_val("basic_flags", {out_blank, out_invalid}, 0);
    check_val("basic_count", glyph_count, model_count);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check_val("basic_drained", out_valid, 0);

    // Full table sweep, then blank, then 0x01 which aliases blank.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) sweep[i] = glyph_tab[i];
    sweep[16] = 8'h00;
    sweep[17] = 8'h01;
    for (int i = 0; i < 18; i++) hold_glyph(sweep[i], 10);
    check_val("sweep_count", glyph_count, model_count);

    // Invalid pattern.
    hold_glyph(8'h80, 10);

    // Glitch rejection.
    hold_glyph(8'h0C, 10);
    hold_glyph(8'hFE, 3);
    hold_glyph(8'h0C, 10);
    check_val("glitch_count", glyph_count, model_count);
    check_val("sweep_drained", sb_q.size(), 0);

    // Overrun: second glyph overwrites the unconsumed first.
    do_reset();
    replace_mode = 1'b1;
    hold_glyph(8'h0C, 10);
    hold_glyph(8'hB6, 10);
    check_val("ovr_code", out_code, 2);
    check_val("ovr_flag", overrun, 1);
    check_val("ovr_count", glyph_count, model_count);
    replace_mode = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    // Rerun with ready pulsed on the second accept edge: no overrun.
    do_reset();
    hold_glyph(8'h0C, 10);
    drive_glyph(8'hB6, 10);
    repeat (STABLE + 2) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check_val("noovr_flag", overrun, 0);
    check_val("noovr_valid", out_valid, 1);
    check_val("noovr_code", out_code, 2);
    check_val("noovr_count", glyph_count, model_count);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check_val("noovr_drained", sb_q.size(), 0);

    // Async reset while FULL, away from any clock edge.
    hold_glyph(8'hCC, 10);
    check_val("full_before_rst", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_valid", out_valid, 0);
    check_val("arst_code", out_code, 0);
    check_val("arst_count", glyph_count, 0);
    check_val("arst_ovr", overrun, 0);
    do_reset();

    // Async reset mid-settle: nothing may emerge from the aborted pattern.
    seg_in = 8'hDA;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_val("arst_settle_valid", out_valid, 0);
    do_reset();
    repeat (12) @(posedge clk);
    #1 check_val("settle_no_accept", glyph_count, 0);

    // Counter wrap over 257 accepts.
    out_ready = 1'b1;
    for (int i = 0; i < 257; i++) hold_glyph((i % 2 == 0) ? 8'h0C : 8'hB6, STABLE + 2);
    repeat (2) @(posedge clk);
    #1 check_val("wrap_count", glyph_count, model_count);
    check_val("wrap_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
